// File: rtl/upc_checkout.sv
// Checkout-lane scan controller: table lookup of {code, mark}, registered D/S flags,
// saturating item/discount tallies and a sticky theft alarm. Optional macro: UPC_ALARM_HOLD_EN.
module upc_checkout #(
    parameter int CODE_W = 3,
    parameter int CNT_W  = 8,
    parameter logic [2**(CODE_W+1)-1:0] DISC_TABLE   = 16'h1C40,
    parameter logic [2**(CODE_W+1)-1:0] STOLEN_TABLE = 16'h0501
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scan_valid,
    output logic              scan_ready,
    input  logic [CODE_W-1:0] code,
    input  logic              mark,
    input  logic              checkout,
    input  logic              clear,
    output logic              D,
    output logic              S,
    output logic [CNT_W-1:0]  item_count,
    output logic [CNT_W-1:0]  disc_count,
    output logic              alarm,
    output logic              done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ALARM,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CODE_W:0]   idx;
    logic              d_next;
    logic              s_next;
    logic              accept;

    assign idx    = {code, mark};
    assign d_next = DISC_TABLE[idx];
    assign s_next = STOLEN_TABLE[idx];
    assign accept = scan_valid & scan_ready;
    assign done   = (state == DONE);

    // A pending clear blocks acceptance so the cleared transaction starts empty.
    always_comb begin
        scan_ready = 1'b0;
        case (state)
            IDLE:  scan_ready = 1'b1;
            SCAN:  scan_ready = 1'b1;
            ALARM: begin
`ifdef UPC_ALARM_HOLD_EN
                scan_ready = 1'b0;
`else
                scan_ready = 1'b1;
`endif
            end
            default: scan_ready = 1'b0;
        endcase
        if (clear) begin
            scan_ready = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_next = s_next ? ALARM : SCAN;
                    end
                    if (checkout) begin
                        state_next = DONE;
                    end
                end
                SCAN: begin
                    if (accept && s_next) begin
                        state_next = ALARM;
                    end
                    if (checkout) begin
                        state_next = DONE;
                    end
                end
                ALARM: begin
                    if (checkout) begin
                        state_next = DONE;
                    end
                end
                default: state_next = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Tallies saturate rather than wrap so a long transaction never looks short.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            D          <= 1'b0;
            S          <= 1'b0;
            item_count <= '0;
            disc_count <= '0;
            alarm      <= 1'b0;
        end else if (clear) begin
            D          <= 1'b0;
            S          <= 1'b0;
            item_count <= '0;
            disc_count <= '0;
            alarm      <= 1'b0;
        end else if (accept) begin
            D <= d_next;
            S <= s_next;
            if (item_count != CNT_MAX) begin
                item_count <= item_count + 1'b1;
            end
            if (d_next && (disc_count != CNT_MAX)) begin
                disc_count <= disc_count + 1'b1;
            end
            if (s_next) begin
                alarm <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_upc_checkout.sv
// Self-checking bench for upc_checkout: directed scenarios plus random scans, checked
// every cycle against a transaction-level model; a CNT_W=2 copy exercises saturation.
module tb_upc_checkout;

`ifdef UPC_ALARM_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       scan_valid;
    logic [2:0] code;
    logic       mark;
    logic       checkout;
    logic       clear;

    logic       scan_ready, D, S, alarm, done;
    logic [7:0] item_count, disc_count;
    logic       scan_ready2, D2, S2, alarm2, done2;
    logic [1:0] item_count2, disc_count2;

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    upc_checkout #(.CODE_W(3), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_ready(scan_ready),
        .code(code), .mark(mark), .checkout(checkout), .clear(clear),
        .D(D), .S(S), .item_count(item_count), .disc_count(disc_count),
        .alarm(alarm), .done(done)
    );

    upc_checkout #(.CODE_W(3), .CNT_W(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_ready(scan_ready2),
        .code(code), .mark(mark), .checkout(checkout), .clear(clear),
        .D(D2), .S(S2), .item_count(item_count2), .disc_count(disc_count2),
        .alarm(alarm2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: totals kept unbounded, saturation applied when comparing.
    int m_items = 0;
    int m_disc  = 0;
    bit m_d     = 1'b0;
    bit m_s     = 1'b0;
    bit m_alarm = 1'b0;
    bit m_done  = 1'b0;

    function automatic bit is_disc(input int i);
        return (i == 6) || (i == 10) || (i == 11) || (i == 12);
    endfunction

    function automatic bit is_stolen(input int i);
        return (i == 0) || (i == 8) || (i == 10);
    endfunction

    function automatic bit model_ready();
        return !clear && !m_done && !(HOLD && m_alarm);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_items <= 0; m_disc <= 0; m_d <= 1'b0; m_s <= 1'b0;
            m_alarm <= 1'b0; m_done <= 1'b0;
        end else if (clear) begin
            m_items <= 0; m_disc <= 0; m_d <= 1'b0; m_s <= 1'b0;
            m_alarm <= 1'b0; m_done <= 1'b0;
        end else begin
            if (scan_valid && model_ready()) begin
                m_items <= m_items + 1;
                m_disc  <= m_disc + (is_disc(int'({code, mark})) ? 1 : 0);
                m_d     <= is_disc(int'({code, mark}));
                m_s     <= is_stolen(int'({code, mark}));
                if (is_stolen(int'({code, mark}))) m_alarm <= 1'b1;
            end
            if (checkout) m_done <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("scan_ready",  int'(scan_ready),  int'(model_ready()));
            checkOutput("D",           int'(D),           int'(m_d));
            checkOutput("S",           int'(S),           int'(m_s));
            checkOutput("item_count",  int'(item_count),  sat(m_items, 255));
            checkOutput("disc_count",  int'(disc_count),  sat(m_disc, 255));
            checkOutput("alarm",       int'(alarm),       int'(m_alarm));
            checkOutput("done",        int'(done),        int'(m_done));
            checkOutput("item_count2", int'(item_count2), sat(m_items, 3));
            checkOutput("disc_count2", int'(disc_count2), sat(m_disc, 3));
            checkOutput("scan_ready2", int'(scan_ready2), int'(model_ready()));
        end
    end

    // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
    task automatic applyStimulus(input logic v, input logic [2:0] c, input logic m,
                                 input logic co, input logic cl, input logic rn);
        scan_valid = v;
        code       = c;
        mark       = m;
        checkout   = co;
        clear      = cl;
        reset_n    = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] sweep_idx;
        reset_n = 1'b0; scan_valid = 1'b0; code = 3'd0; mark = 1'b0;
        checkout = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        check_en = 1'b1;
        checkOutput("rst_item", int'(item_count), 0);
        checkOutput("rst_ready", int'(scan_ready), 1);
        checkOutput("rst_alarm", int'(alarm), 0);

        applyStimulus(1, 3'b011, 0, 0, 0, 1);
        checkOutput("lit1_D", int'(D), 1);
        checkOutput("lit1_S", int'(S), 0);
        checkOutput("lit1_item", int'(item_count), 1);
        checkOutput("lit1_disc", int'(disc_count), 1);
        checkOutput("lit1_alarm", int'(alarm), 0);

        applyStimulus(1, 3'b101, 0, 0, 0, 1);
        checkOutput("lit2_D", int'(D), 1);
        checkOutput("lit2_S", int'(S), 1);
        checkOutput("lit2_alarm", int'(alarm), 1);
        checkOutput("lit2_item", int'(item_count), 2);

        applyStimulus(1, 3'b001, 0, 0, 0, 1);
        checkOutput("lit3_item", int'(item_count), HOLD ? 2 : 3);
        checkOutput("lit3_D", int'(D), HOLD ? 1 : 0);
        checkOutput("lit3_alarm", int'(alarm), 1);

        applyStimulus(0, 3'b000, 0, 0, 1, 1);
        checkOutput("clr_item", int'(item_count), 0);
        checkOutput("clr_alarm", int'(alarm), 0);

        for (int i = 0; i < 16; i++) begin
            sweep_idx = 4'(i);
            applyStimulus(1, sweep_idx[3:1], sweep_idx[0], 0, 0, 1);
        end
        checkOutput("sweep_item", int'(item_count), HOLD ? 1 : 16);
        checkOutput("sweep_disc", int'(disc_count), HOLD ? 0 : 4);
        checkOutput("sweep_disc2", int'(disc_count2), HOLD ? 0 : 3);

        applyStimulus(0, 3'b000, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(1, 3'b011, 0, 0, 0, 1);
        checkOutput("sat_item", int'(item_count), 5);
        checkOutput("sat_disc", int'(disc_count), 5);
        checkOutput("sat_item2", int'(item_count2), 3);
        checkOutput("sat_disc2", int'(disc_count2), 3);

        applyStimulus(0, 3'b000, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 3'b011, 0, 0, 0, 1);
        applyStimulus(0, 3'b000, 0, 0, 0, 1);
        checkOutput("pre_rst_item", int'(item_count), 3);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_item", int'(item_count), 0);
        checkOutput("async_rst_disc", int'(disc_count), 0);
        checkOutput("async_rst_D", int'(D), 0);
        checkOutput("async_rst_ready", int'(scan_ready), 1);
        checkOutput("async_rst_done", int'(done), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1, 3'b011, 0, 1, 0, 1);
        checkOutput("co_item", int'(item_count), 1);
        checkOutput("co_done", int'(done), 1);
        checkOutput("co_ready", int'(scan_ready), 0);
        applyStimulus(1, 3'b011, 0, 0, 0, 1);
        checkOutput("done_frozen", int'(item_count), 1);
        applyStimulus(1, 3'b011, 0, 0, 1, 1);
        checkOutput("clr_done", int'(done), 0);
        checkOutput("clr_ready", int'(scan_ready), 0);
        applyStimulus(0, 3'b000, 0, 0, 0, 1);
        checkOutput("clr_no_accept", int'(item_count), 0);
        checkOutput("idle_ready", int'(scan_ready), 1);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
        end

        applyStimulus(0, 3'b000, 0, 0, 0, 1);
        check_en = 1'b0;
        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
